// File: rtl/error_log_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : err_log_pkg
// Description : Shared types and constants for the error log buffer.
//               err_log_entry_t is the 96-bit {ts, data} entry stored in the
//               ring. The error type field sits in data[22:18].
// Revision    : 1.0 - initial release
// ============================================================================
package err_log_pkg;

    typedef struct packed {
        logic [31:0] ts;
        logic [63:0] data;
    } err_log_entry_t;

    localparam int ERR_TYPE_LSB = 18;
    localparam int ERR_TYPE_MSB = 22;
    localparam int OVF_CNT_W    = 16;

endpackage : err_log_pkg
`default_nettype wire

// File: rtl/error_log_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : error_log_buffer_if
// Description : Bundles the error log buffer's logging port, software read
//               port, statistics and interrupt.
//               master : detector / software side (drives log_*, rd_en, log_clear)
//               slave  : error_log_buffer
// Revision    : 1.0 - initial release
// ============================================================================
interface error_log_buffer_if
    import err_log_pkg::*;
#(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 log_valid;
    logic [63:0]          log_data;
    logic [31:0]          log_timestamp;
    logic                 rd_en;
    logic                 log_clear;
    logic                 rd_valid;
    logic [95:0]          rd_entry;
    logic [CNT_W-1:0]     count;
    logic                 empty;
    logic                 full;
    logic [OVF_CNT_W-1:0] overflow_cnt;
    logic                 first_valid;
    logic [95:0]          first_entry;
    logic                 irq_watermark;

    modport master (
        output log_valid, log_data, log_timestamp, rd_en, log_clear,
        input  rd_valid, rd_entry, count, empty, full, overflow_cnt,
               first_valid, first_entry, irq_watermark
    );

    modport slave (
        input  log_valid, log_data, log_timestamp, rd_en, log_clear,
        output rd_valid, rd_entry, count, empty, full, overflow_cnt,
               first_valid, first_entry, irq_watermark
    );

endinterface : error_log_buffer_if
`default_nettype wire

// File: rtl/error_log_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : err_log_ram
// Description : Simple dual-port entry store, DEPTH x err_log_entry_t.
//               One write port, one registered read port.
// Ports       : clk, rst      - clock, async active-high reset (read reg only)
//               wr_en/addr/data - write port
//               rd_en/addr    - read request; rd_data valid after the edge
//               rd_data       - registered read data, holds when rd_en=0
// Revision    : 1.0 - initial release
// ============================================================================
module err_log_ram
    import err_log_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           wr_en,
    input  wire logic [PTR_W-1:0] wr_addr,
    input  wire err_log_entry_t wr_data,
    input  wire logic           rd_en,
    input  wire logic [PTR_W-1:0] rd_addr,
    output err_log_entry_t      rd_data
);

    err_log_entry_t r_mem [DEPTH];

    // Storage array is never reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-edge write to rd_addr returns the old entry,
    // which is what a pop of the oldest slot on a full ring needs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule : err_log_ram
`default_nettype wire

// File: rtl/error_log_buffer.sv
`default_nettype none
// ============================================================================
// Module      : error_log_buffer
// Description : Circular capture buffer for error detector log words.
//               Accepts a write every cycle, single-entry pop port, overflow
//               counter, first-error capture and watermark interrupt.
//               Build option ERR_LOG_OVERWRITE_EN: when defined, a write to a
//               full buffer overwrites the oldest entry; otherwise it is
//               dropped. Either way overflow_cnt counts the lost entry.
// Ports       : clk, rst (async active-high), bus (error_log_buffer_if.slave)
// Revision    : 1.0 - initial release
// ============================================================================
module error_log_buffer
    import err_log_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int WATERMARK = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    error_log_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef ERR_LOG_OVERWRITE_EN
    localparam bit OVERWRITE = 1'b1;
`else
    localparam bit OVERWRITE = 1'b0;
`endif

    logic [PTR_W-1:0]     r_wp;
    logic [PTR_W-1:0]     r_rp;
    logic [CNT_W-1:0]     r_count;
    logic [OVF_CNT_W-1:0] r_ovf;
    logic                 r_first_valid;
    err_log_entry_t       r_first_entry;
    logic                 r_rd_valid;
    logic                 r_irq;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_lost;
    logic                 w_store;
    logic                 w_rp_adv;
    logic [CNT_W-1:0]     w_count_nxt;
    err_log_entry_t       w_entry;
    err_log_entry_t       w_rd_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_entry = err_log_entry_t'({bus.log_timestamp, bus.log_data});

    // log_clear swallows any concurrent write or pop.
    assign w_wr     = bus.log_valid & ~bus.log_clear;
    assign w_rd     = bus.rd_en & ~bus.log_clear & ~w_empty;
    // A write into a full ring without a pop loses an entry: the new one
    // (drop build) or the oldest one (overwrite build).
    assign w_lost   = w_wr & w_full & ~w_rd;
    assign w_store  = w_wr & (~w_full | w_rd | OVERWRITE);
    // Overwriting the oldest slot drags the read pointer along.
    assign w_rp_adv = w_rd | (w_lost & OVERWRITE);

    always_comb begin
        w_count_nxt = r_count;
        if (w_store && !w_rd && !w_full) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_rd && !w_store) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp          <= '0;
            r_rp          <= '0;
            r_count       <= '0;
            r_ovf         <= '0;
            r_first_valid <= 1'b0;
            r_first_entry <= '0;
            r_rd_valid    <= 1'b0;
            r_irq         <= 1'b0;
        end else if (bus.log_clear) begin
            // first_entry and the storage array keep their old contents.
            r_wp          <= '0;
            r_rp          <= '0;
            r_count       <= '0;
            r_ovf         <= '0;
            r_first_valid <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_irq         <= 1'b0;
        end else begin
            if (w_store) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_rp_adv) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            if (w_lost && (r_ovf != '1)) begin
                r_ovf <= r_ovf + OVF_CNT_W'(1);
            end
            if (w_store && !r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_entry <= w_entry;
            end
            r_rd_valid <= w_rd;
            r_irq      <= (w_count_nxt >= CNT_W'(WATERMARK));
        end
    end

    err_log_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_store),
        .wr_addr (r_wp),
        .wr_data (w_entry),
        .rd_en   (w_rd),
        .rd_addr (r_rp),
        .rd_data (w_rd_data)
    );

    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_entry      = w_rd_data;
    assign bus.count         = r_count;
    assign bus.empty         = w_empty;
    assign bus.full          = w_full;
    assign bus.overflow_cnt  = r_ovf;
    assign bus.first_valid   = r_first_valid;
    assign bus.first_entry   = r_first_entry;
    assign bus.irq_watermark = r_irq;

endmodule : error_log_buffer
`default_nettype wire

// File: tb/tb_error_log_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_error_log_buffer
// Description : Directed self-checking bench for error_log_buffer
//               (DEPTH=16, WATERMARK=8). Honours ERR_LOG_OVERWRITE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_error_log_buffer;

    localparam int DEPTH     = 16;
    localparam int WATERMARK = 8;
`ifdef ERR_LOG_OVERWRITE_EN
    localparam int OLD_BASE = 4;
`else
    localparam int OLD_BASE = 0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    error_log_buffer_if #(.DEPTH(DEPTH)) bus ();

    error_log_buffer #(
        .DEPTH     (DEPTH),
        .WATERMARK (WATERMARK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs/outputs are touched 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ts, input logic [63:0] d);
        bus.log_valid     = 1'b1;
        bus.log_timestamp = ts;
        bus.log_data      = d;
        tick();
        bus.log_valid     = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic clear();
        bus.log_clear = 1'b1;
        tick();
        bus.log_clear = 1'b0;
    endtask

    initial begin
        logic [4:0] types [3];
        types[0] = 5'd8; types[1] = 5'd2; types[2] = 5'd5;
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.log_valid = 1'b0; bus.log_data = '0; bus.log_timestamp = '0;
        bus.rd_en = 1'b0; bus.log_clear = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count",  128'(bus.count), 128'd0);
        chk("rst_empty",  128'(bus.empty), 128'd1);
        chk("rst_full",   128'(bus.full), 128'd0);
        chk("rst_ovf",    128'(bus.overflow_cnt), 128'd0);
        chk("rst_fvalid", 128'(bus.first_valid), 128'd0);
        chk("rst_fentry", 128'(bus.first_entry), 128'd0);
        chk("rst_rdv",    128'(bus.rd_valid), 128'd0);
        chk("rst_rdent",  128'(bus.rd_entry), 128'd0);
        chk("rst_irq",    128'(bus.irq_watermark), 128'd0);
        rst = 1'b0;
        tick();

        // ---- three entries in, three out, in order ----
        for (int i = 0; i < 3; i++) push(32'(100 + i), 64'(types[i]) << 18);
        chk("w3_count",  128'(bus.count), 128'd3);
        chk("w3_fvalid", 128'(bus.first_valid), 128'd1);
        chk("w3_fts",    128'(bus.first_entry[95:64]), 128'd100);
        for (int i = 0; i < 3; i++) begin
            pop();
            chk("p3_rdv",   128'(bus.rd_valid), 128'd1);
            chk("p3_type",  128'(bus.rd_entry[22:18]), 128'(types[i]));
            chk("p3_ts",    128'(bus.rd_entry[95:64]), 128'(100 + i));
            chk("p3_count", 128'(bus.count), 128'(2 - i));
        end
        tick();
        chk("p3_rdv_low", 128'(bus.rd_valid), 128'd0);
        chk("p3_hold",    128'(bus.rd_entry[95:64]), 128'd102);
        chk("p3_empty",   128'(bus.empty), 128'd1);
        pop();
        chk("pop_empty_rdv", 128'(bus.rd_valid), 128'd0);

        // ---- watermark ----
        for (int i = 0; i < 7; i++) push(32'(i), 64'(i));
        chk("wm7_irq", 128'(bus.irq_watermark), 128'd0);
        push(32'd7, 64'd7);
        chk("wm8_irq", 128'(bus.irq_watermark), 128'd1);
        pop();
        chk("wm_pop_irq", 128'(bus.irq_watermark), 128'd0);
        chk("wm_pop_cnt", 128'(bus.count), 128'd7);
        clear();
        chk("clr_count", 128'(bus.count), 128'd0);

        // ---- 20 writes into a 16-deep ring ----
        for (int i = 0; i < 20; i++) push(32'(i), 64'(i) << 18);
        chk("ov_cnt",   128'(bus.overflow_cnt), 128'd4);
        chk("ov_full",  128'(bus.full), 128'd1);
        chk("ov_count", 128'(bus.count), 128'd16);
        chk("ov_fts",   128'(bus.first_entry[95:64]), 128'd0);
        for (int i = 0; i < 16; i++) begin
            pop();
            chk("ov_pop_ts", 128'(bus.rd_entry[95:64]), 128'(OLD_BASE + i));
        end
        chk("ov_drained", 128'(bus.empty), 128'd1);

        // ---- full + simultaneous write/pop ----
        clear();
        for (int i = 0; i < 16; i++) push(32'(200 + i), 64'(i));
        bus.rd_en = 1'b1;
        push(32'd300, 64'hABCD);
        bus.rd_en = 1'b0;
        chk("fs_rdv",   128'(bus.rd_valid), 128'd1);
        chk("fs_ts",    128'(bus.rd_entry[95:64]), 128'd200);
        chk("fs_count", 128'(bus.count), 128'd16);
        chk("fs_ovf",   128'(bus.overflow_cnt), 128'd0);
        pop();
        chk("fs_next",  128'(bus.rd_entry[95:64]), 128'd201);

        // ---- empty + simultaneous write/pop: no bypass ----
        clear();
        bus.rd_en = 1'b1;
        push(32'd55, 64'd55);
        bus.rd_en = 1'b0;
        chk("es_rdv",   128'(bus.rd_valid), 128'd0);
        chk("es_count", 128'(bus.count), 128'd1);
        pop();
        chk("es_ts",    128'(bus.rd_entry[95:64]), 128'd55);

        // ---- clear beats a concurrent write ----
        clear();
        for (int i = 0; i < 5; i++) push(32'(400 + i), 64'(i));
        bus.log_clear = 1'b1;
        push(32'd999, 64'd999);
        bus.log_clear = 1'b0;
        chk("cw_count",  128'(bus.count), 128'd0);
        chk("cw_fvalid", 128'(bus.first_valid), 128'd0);
        chk("cw_ovf",    128'(bus.overflow_cnt), 128'd0);
        chk("cw_empty",  128'(bus.empty), 128'd1);

        // ---- asynchronous reset mid-cycle with 4 entries held ----
        for (int i = 0; i < 5; i++) push(32'(500 + i), 64'(i + 1));
        pop();
        chk("ar_pre_cnt", 128'(bus.count), 128'd4);
        chk("ar_pre_rd",  128'(bus.rd_entry[95:64]), 128'd500);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count",  128'(bus.count), 128'd0);
        chk("ar_empty",  128'(bus.empty), 128'd1);
        chk("ar_fvalid", 128'(bus.first_valid), 128'd0);
        chk("ar_fentry", 128'(bus.first_entry), 128'd0);
        chk("ar_rdent",  128'(bus.rd_entry), 128'd0);
        chk("ar_rdv",    128'(bus.rd_valid), 128'd0);
        chk("ar_irq",    128'(bus.irq_watermark), 128'd0);
        chk("ar_ovf",    128'(bus.overflow_cnt), 128'd0);
        tick();
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_error_log_buffer
`default_nettype wire

// File: doc/error_log_buffer.md
# error_log_buffer

Downstream consumer of the error detector's logging port. Captures every `log_valid` pulse (64-bit log word plus 32-bit timestamp) into a circular entry store. Software drains the store through a single-entry read port. Also keeps:
- an overflow counter,
- a first-error capture register,
- a watermark interrupt.

The detector has no backpressure, so this block accepts a write on every cycle.

## Interface
- `DEPTH`, 16: entry count; power of two, ≥2.
- `WATERMARK`, 8: `irq_watermark` asserts when occupancy ≥ this value; range 1..`DEPTH`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `log_valid` in 1: one-cycle strobe from the error detector.
- `log_data` in 64: log word; error type is in bits [22:18].
- `log_timestamp` in 32: timestamp paired with `log_data`.
- `rd_en` in 1: pop request from the software register bridge.
- `rd_valid` out 1: `rd_entry` valid, one-cycle pulse.
- `rd_entry` out 96: {timestamp[31:0], data[63:0]}.
- `log_clear` in 1: flush the store and clear all statistics.
- `count` out $clog2(DEPTH)+1: current occupancy.
- `empty`, `full` out 1: occupancy flags.
- `overflow_cnt` out 16: entries lost or overwritten; saturates at 16'hFFFF.
- `first_valid` out 1: `first_entry` holds data.
- `first_entry` out 96: first entry accepted since reset/clear.
- `irq_watermark` out 1: level interrupt.

## Operation
Storage:
- Ring with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits, wrapping modulo `DEPTH`.
- Occupancy counter runs 0..`DEPTH`.

Write (`log_valid`=1, `log_clear`=0):
- Not full: store at `wp`, then `wp`+1 and `count`+1.
- Full: behaviour set by Configuration.
- Simultaneous `rd_en` while full: the pop frees a slot, the write is accepted normally, `count` is unchanged, `overflow_cnt` is unchanged.

Read (`rd_en`=1):
- Not empty: entry at `rp` is registered to `rd_entry`, `rp`+1, `count`−1.
- Empty: ignored; no bypass from a same-cycle write; `rd_valid` stays 0.
- Simultaneous read and write while not empty and not full: `count` is unchanged.

First-error capture:
- On the first accepted write after reset/clear, `first_entry` ← {ts, data} and `first_valid` ← 1.
- Held until the next clear. Not affected by reads or by overwrites.

`log_clear`:
- Has priority over everything in the same cycle; any concurrent write or read is discarded.
- Zeroes `wp`, `rp`, `count`, `overflow_cnt`, `first_valid`, `rd_valid`.
- Storage contents are not cleared.

`overflow_cnt`: +1 per lost or overwritten entry; holds at 16'hFFFF.

## Timing
- Reset values: `rd_valid`=0, `rd_entry`=0, `count`=0, `empty`=1, `full`=0, `overflow_cnt`=0, `first_valid`=0, `first_entry`=0, `irq_watermark`=0.
- Write latency: entry is accepted at the edge where `log_valid`=1; `count`/`empty`/`full` update on that edge.
- Write-to-read: an entry written at edge N can be popped by `rd_en` sampled at edge N+1.
- Read latency: `rd_en` sampled at edge N gives `rd_valid`=1 with `rd_entry` after edge N, for one cycle.
- `rd_entry` holds its last value when `rd_valid`=0.
- `irq_watermark` is registered: it reflects `count` ≥ `WATERMARK` computed from the post-update count of the same edge.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous).

## Configuration
- `ERR_LOG_OVERWRITE_EN` defined:
  - Write when full (no concurrent pop) overwrites the oldest entry: store at `wp`, `wp`+1, `rp`+1, `count` stays `DEPTH`, `overflow_cnt`+1.
  - The buffer keeps the newest `DEPTH` errors.
- `ERR_LOG_OVERWRITE_EN` undefined:
  - Write when full is dropped: no pointer change, `overflow_cnt`+1.
  - The buffer keeps the oldest `DEPTH` errors.
- `first_entry` behaviour is identical in both builds.

## Structure
Package `err_log_pkg`:
- `err_log_entry_t` packed struct {logic [31:0] ts; logic [63:0] data;}.
- Constants `ERR_TYPE_LSB`=18, `ERR_TYPE_MSB`=22.
- Constant `OVF_CNT_W`=16.

Sub-module `err_log_ram`:
- Simple dual-port store of `DEPTH` × `err_log_entry_t`: one write port, one registered read port.
- Control logic (pointers, counters, capture, irq) lives in `error_log_buffer`.

## Test plan
- Reset; write 3 entries (data 64'h8<<18, 64'h2<<18, 64'h5<<18; ts 100, 101, 102); pop 3 → `rd_entry` returns in order, types 8, 2, 5; `count` 3→0; `empty`=1; `first_entry`.ts=100.
- Write 8 entries with `WATERMARK`=8 → `irq_watermark`=1 after the 8th write edge; one pop → `irq_watermark`=0 the following cycle.
- Write 20 entries with ts 0..19, no reads:
  - Without the macro: `overflow_cnt`=4, pops return ts 0..15.
  - With `ERR_LOG_OVERWRITE_EN`: `overflow_cnt`=4, pops return ts 4..19.
  - Both: `first_entry`.ts=0.
- Full buffer; `log_valid` and `rd_en` in the same cycle → oldest entry is read, new entry is stored, `count`=16, `overflow_cnt`=0.
- Empty buffer; `log_valid` and `rd_en` in the same cycle → `rd_valid`=0, `count`=1.
- Write 5 entries; assert `log_clear` together with `log_valid` → `count`=0, `first_valid`=0, `overflow_cnt`=0. Then assert `rst` while 4 entries are held → all outputs are at their reset values before the next clock edge.
